// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the I2C character-display sequencer
//
// Purpose: state encoding, controller init ROM, control-byte values, DDRAM
// addressing constants and frame-buffer geometry used by lcd_cmd_sequencer.
// Ports: none (package).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_READY
  } lcd_state_e;

  localparam logic [7:0] LCD_SLAVE_ADDR = 8'h7C;
  localparam logic [7:0] LCD_CTRL_CMD   = 8'h00;
  localparam logic [7:0] LCD_CTRL_DATA  = 8'h40;
  localparam logic [7:0] LCD_SET_DDRAM  = 8'h80;
  localparam logic [7:0] LCD_ROW0_BASE  = 8'h00;
  localparam logic [7:0] LCD_ROW1_BASE  = 8'h40;

  // Commands whose execution time exceeds the ordinary command delay.
  localparam logic [7:0] LCD_CMD_FOLLOWER = 8'h6C;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;

  localparam logic [7:0] LCD_CHAR_SPACE = 8'h20;
  localparam int         FB_DEPTH       = 32;

  // Power-up init sequence; entry 0 sits in the least significant byte.
  localparam int INIT_LEN = 9;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    8'h01, 8'h0C, 8'h38, 8'h6C, 8'h56, 8'h70, 8'h14, 8'h39, 8'h38
  };

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter with one-cycle expiry pulse
//
// Purpose: counts a loaded value down to zero; expired pulses for exactly one
// cycle when the count reaches zero, i.e. value+1 cycles after the load.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - load value into the counter and start it
//   value     - 32-bit count to load
//   expired   - one-cycle pulse when a started count reaches zero
module lcd_delay_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  output logic        expired
);

  logic [31:0] cnt_q, cnt_d;
  logic        run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = value;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 32'd0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expired = run_q && (cnt_q == 32'd0);

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - init and frame-buffer refresh sequencer for a 2x16 I2C LCD
//
// Purpose: after start, waits the power-up time, streams the init ROM, then
// keeps a 32-byte frame buffer and redraws both rows whenever it is written
// or a refresh is requested. Each (ctrl, byte) pair is handed to the I2C
// transmitter and followed by the controller execution delay.
// Optional feature: define LCD_SEQ_AUTO_START_EN to leave IDLE without start.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin init while IDLE
//   char_we/addr/data   - frame-buffer write (addr bit4 = row, bits3:0 = column)
//   refresh             - request full-screen redraw
//   tx_valid/ready      - pair handshake to transmitter; tx_ctrl/tx_byte payload
//   tx_done, tx_nack    - transfer finished pulse, NACK qualifier
//   init_done, busy, err - status (err is sticky until reset)
module lcd_cmd_sequencer
  import lcd_pkg::*;
#(
  parameter int CYCLES_PER_US = 100,
  parameter int POWERUP_US    = 40000,
  parameter int CMD_US        = 30,
  parameter int FOLLOWER_US   = 200000,
  parameter int CLEAR_US      = 1100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       char_we,
  input  logic [4:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       refresh,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_ctrl,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_nack,
  output logic       init_done,
  output logic       busy,
  output logic       err
);

  // Timer loads N-1 so that expiry lands exactly N cycles after the load.
  localparam logic [31:0] POWERUP_CYC  = 32'(POWERUP_US * CYCLES_PER_US - 1);
  localparam logic [31:0] CMD_CYC      = 32'(CMD_US * CYCLES_PER_US - 1);
  localparam logic [31:0] FOLLOWER_CYC = 32'(FOLLOWER_US * CYCLES_PER_US - 1);
  localparam logic [31:0] CLEAR_CYC    = 32'(CLEAR_US * CYCLES_PER_US - 1);

  lcd_state_e  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        row_q, row_d;
  logic [4:0]  step_q, step_d;      // 0 = DDRAM address command, 1..16 = columns done
  logic [7:0]  tx_ctrl_q, tx_ctrl_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        init_done_q, init_done_d;
  logic        err_q, err_d;
  logic        pending_q, pending_d;
  logic [7:0]  buf_q [FB_DEPTH];
  logic [7:0]  buf_d [FB_DEPTH];

  logic        tmr_load;
  logic [31:0] tmr_value;
  logic        tmr_expired;
  logic        go;

`ifdef LCD_SEQ_AUTO_START_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  lcd_delay_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_comb begin
    buf_d = buf_q;
    if (char_we) begin
      buf_d[char_addr] = char_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    step_d      = step_q;
    tx_ctrl_d   = tx_ctrl_q;
    tx_byte_d   = tx_byte_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    // Writes are remembered in every state so the screen always converges.
    pending_d   = pending_q | char_we | refresh;
    tmr_load    = 1'b0;
    tmr_value   = CMD_CYC;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          tmr_load  = 1'b1;
          tmr_value = POWERUP_CYC;
          state_d   = ST_PWRUP;
        end
      end

      ST_PWRUP: begin
        if (tmr_expired) begin
          idx_d     = 4'd0;
          tx_ctrl_d = LCD_CTRL_CMD;
          tx_byte_d = INIT_ROM[0];
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (tx_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (tx_nack) begin
            err_d       = 1'b1;
            init_done_d = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            if (tx_ctrl_q == LCD_CTRL_CMD && tx_byte_q == LCD_CMD_FOLLOWER) begin
              tmr_value = FOLLOWER_CYC;
            end else if (tx_ctrl_q == LCD_CTRL_CMD && tx_byte_q == LCD_CMD_CLEAR) begin
              tmr_value = CLEAR_CYC;
            end
            state_d = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        if (tmr_expired) begin
          if (!init_done_q) begin
            if (idx_q == 4'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
              state_d     = ST_READY;
            end else begin
              idx_d     = idx_q + 4'd1;
              tx_ctrl_d = LCD_CTRL_CMD;
              tx_byte_d = INIT_ROM[idx_q + 4'd1];
              state_d   = ST_SEND;
            end
          end else if (step_q == 5'd16) begin
            if (row_q) begin
              state_d = ST_READY;
            end else begin
              row_d     = 1'b1;
              step_d    = 5'd0;
              tx_ctrl_d = LCD_CTRL_CMD;
              tx_byte_d = LCD_SET_DDRAM | LCD_ROW1_BASE;
              state_d   = ST_SEND;
            end
          end else begin
            // Byte is taken from the registered buffer, so a same-cycle
            // write to this address is sent on the next pass.
            step_d    = step_q + 5'd1;
            tx_ctrl_d = LCD_CTRL_DATA;
            tx_byte_d = buf_q[{row_q, step_q[3:0]}];
            state_d   = ST_SEND;
          end
        end
      end

      ST_READY: begin
        if (pending_q) begin
          pending_d = char_we | refresh;
          row_d     = 1'b0;
          step_d    = 5'd0;
          tx_ctrl_d = LCD_CTRL_CMD;
          tx_byte_d = LCD_SET_DDRAM | LCD_ROW0_BASE;
          state_d   = ST_SEND;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      row_q       <= 1'b0;
      step_q      <= 5'd0;
      tx_ctrl_q   <= 8'h00;
      tx_byte_q   <= 8'h00;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      pending_q   <= 1'b0;
      buf_q       <= '{default: LCD_CHAR_SPACE};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      step_q      <= step_d;
      tx_ctrl_q   <= tx_ctrl_d;
      tx_byte_q   <= tx_byte_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      pending_q   <= pending_d;
      buf_q       <= buf_d;
    end
  end

  assign tx_valid  = (state_q == ST_SEND);
  assign tx_ctrl   = tx_ctrl_q;
  assign tx_byte   = tx_byte_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_READY);

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       char_we = 1'b0;
  logic [4:0] char_addr = 5'd0;
  logic [7:0] char_data = 8'd0;
  logic       refresh = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_nack = 1'b0;
  logic       tx_valid, init_done, busy, err;
  logic [7:0] tx_ctrl, tx_byte;

  lcd_cmd_sequencer #(
    .CYCLES_PER_US (1),
    .POWERUP_US    (10),
    .CMD_US        (3),
    .FOLLOWER_US   (20),
    .CLEAR_US      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .char_we   (char_we),
    .char_addr (char_addr),
    .char_data (char_data),
    .refresh   (refresh),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_ctrl   (tx_ctrl),
    .tx_byte   (tx_byte),
    .tx_done   (tx_done),
    .tx_nack   (tx_nack),
    .init_done (init_done),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] data;
    int         t;
  } pair_t;

  pair_t log_q[$];
  logic  ready_en = 1'b1;
  int    done_cnt = 0;
  int    nack_at = -1;

  // Transmitter model: accepts when ready, pulses tx_done 5 cycles later.
  always @(negedge clk) begin
    tx_done = 1'b0;
    tx_nack = 1'b0;
    tx_ready = ready_en;
    if (rst) begin
      done_cnt = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          tx_done = 1'b1;
          tx_nack = ((log_q.size() - 1) == nack_at);
        end
      end
      if (tx_valid && tx_ready) begin
        log_q.push_back('{tx_ctrl, tx_byte, cyc});
        done_cnt = 5;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] img [32];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_ctrl"}, tx_ctrl, 8'h00);
    chk({tag, "_tx_byte"}, tx_byte, 8'h00);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic wait_ready(input int n, input int budget, input string name);
    int k = 0;
    while ((log_q.size() < n || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_complete"}, (log_q.size() >= n) && !busy, 1);
  endtask

  task automatic wait_init(input int budget, input string name);
    int k = 0;
    while (!init_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_init_done"}, init_done, 1);
  endtask

  task automatic check_refresh(input int base, input string name);
    chk({name, "_len"}, log_q.size() >= base + 34, 1);
    if (log_q.size() >= base + 34) begin
      for (int r = 0; r < 2; r++) begin
        int i = base + r * 17;
        chk($sformatf("%s_r%0d_cmd_ctrl", name, r), log_q[i].ctrl, 8'h00);
        chk($sformatf("%s_r%0d_cmd", name, r), log_q[i].data, (r == 1) ? 8'hC0 : 8'h80);
        for (int c = 0; c < 16; c++) begin
          chk($sformatf("%s_r%0d_c%0d_ctrl", name, r, c), log_q[i + 1 + c].ctrl, 8'h40);
          chk($sformatf("%s_r%0d_c%0d_data", name, r, c), log_q[i + 1 + c].data, img[r * 16 + c]);
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] data;
    int         t_rel;   // accept cycle relative to the start cycle
  } vec_t;

  vec_t init_tbl[9];

  initial begin
    int s, base, w, a, t_ready, k;

    // 0x6C is followed by 6+20 cycles, everything else by 6+3.
    init_tbl[0] = '{8'h00, 8'h38, 11};
    init_tbl[1] = '{8'h00, 8'h39, 20};
    init_tbl[2] = '{8'h00, 8'h14, 29};
    init_tbl[3] = '{8'h00, 8'h70, 38};
    init_tbl[4] = '{8'h00, 8'h56, 47};
    init_tbl[5] = '{8'h00, 8'h6C, 56};
    init_tbl[6] = '{8'h00, 8'h38, 82};
    init_tbl[7] = '{8'h00, 8'h0C, 91};
    init_tbl[8] = '{8'h00, 8'h01, 100};
    for (int i = 0; i < 32; i++) img[i] = 8'h20;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Init sequence
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pwrup_busy", busy, 1);
    k = 0;
    while (!init_done && k < 400) begin
      @(negedge clk);
      k++;
    end
    t_ready = cyc;
    chk("init_done_set", init_done, 1);
    chk("init_count", log_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("init%0d_ctrl", i), log_q[i].ctrl, init_tbl[i].ctrl);
        chk($sformatf("init%0d_byte", i), log_q[i].data, init_tbl[i].data);
        chk($sformatf("init%0d_time", i), log_q[i].t - s, init_tbl[i].t_rel);
      end
    end
    chk("init_done_time", t_ready - s, 114);
    chk("ready_not_busy", busy, 0);

    // Single write -> one full redraw
    base = log_q.size();
    char_we = 1'b1; char_addr = 5'h13; char_data = 8'h41;
    w = cyc;
    @(negedge clk);
    char_we = 1'b0;
    img[19] = 8'h41;
    wait_ready(base + 34, 1000, "single");
    check_refresh(base, "single");
    if (log_q.size() > base) chk("refresh_latency", log_q[base].t - w, 2);
    repeat (30) @(negedge clk);
    chk("single_no_extra", log_q.size(), base + 34);

    // Backpressure: held pair must stay stable, exactly one pair emitted after release
    base = log_q.size();
    ready_en = 1'b0;
    char_we = 1'b1; char_addr = 5'h05; char_data = 8'h42;
    @(negedge clk);
    char_we = 1'b0;
    img[5] = 8'h42;
    k = 0;
    while (!tx_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("bp%0d_valid", i), tx_valid, 1);
      chk($sformatf("bp%0d_ctrl", i), tx_ctrl, 8'h00);
      chk($sformatf("bp%0d_byte", i), tx_byte, 8'h80);
      @(negedge clk);
    end
    chk("bp_no_accept", log_q.size(), base);
    ready_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_one_pair", log_q.size(), base + 1);
    wait_ready(base + 34, 1000, "bp");
    check_refresh(base, "bp");

    // Write during refresh to the address whose pair is being loaded
    base = log_q.size();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    k = 0;
    while (log_q.size() < base + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wdr_col1_seen", log_q.size() >= base + 3, 1);
    a = (log_q.size() >= base + 3) ? log_q[base + 2].t : cyc;
    while (cyc < a + 8) @(negedge clk);
    char_we = 1'b1; char_addr = 5'h02; char_data = 8'h55;
    @(negedge clk);
    char_we = 1'b0;
    wait_ready(base + 68, 2000, "wdr");
    if (log_q.size() > base + 3) chk("wdr_col2_time", log_q[base + 3].t, a + 9);
    check_refresh(base, "wdr_pass1");
    img[2] = 8'h55;
    check_refresh(base + 34, "wdr_pass2");

    // Reset during DELAY of a data pair
    base = log_q.size();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    k = 0;
    while (log_q.size() < base + 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    a = (log_q.size() >= base + 2) ? log_q[base + 1].t : cyc;
    while (cyc < a + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) img[i] = 8'h20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_init(400, "reinit");
    base = log_q.size();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_ready(base + 34, 1000, "postrst");
    check_refresh(base, "postrst");

    // NACK on the third init pair
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = log_q.size();
    nack_at = base + 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!err && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("nack_err", err, 1);
    chk("nack_init_done", init_done, 0);
    chk("nack_idle", busy, 0);
    repeat (60) @(negedge clk);
    chk("nack_pairs", log_q.size(), base + 3);
    chk("nack_no_valid", tx_valid, 0);
    chk("nack_err_sticky", err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
